// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] PC_AHEAD = 32'd8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; flush wins over a same-cycle push.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, issues one imem read at a time and
// buffers {pc, instr} for decode; redirect flushes and restarts fetch.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_pc_plus8_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e state_q;
  logic [31:0]  fetch_pc_q, req_addr_q;
  logic [31:0]  redirect_pc_al;
  logic         push, pop;
  logic [CW-1:0] count, count_next;
  logic         fifo_full, fifo_empty;
  fetch_entry_t push_entry, head_entry;

  assign redirect_pc_al = {redirect_pc_i[31:2], 2'b00};
  assign push       = (state_q == REQ) && imem_ack_i && !redirect_valid_i;
  assign pop        = out_valid_o && out_ready_i;
  assign count_next = count + CW'(push) - CW'(pop);
  assign push_entry = '{pc: req_addr_q, instr: imem_rdata_i};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // REQ is only entered with a free slot, so a push never meets a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect_valid_i) begin
            fetch_pc_q <= redirect_pc_al;
          end else if (!fifo_full) begin
            req_addr_q <= fetch_pc_q;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (imem_ack_i && !redirect_valid_i) begin
            fetch_pc_q <= req_addr_q + PC_STEP;
            if (count_next < DEPTH_C) req_addr_q <= req_addr_q + PC_STEP;
            else                      state_q    <= IDLE;
          end else if (imem_ack_i) begin
            fetch_pc_q <= redirect_pc_al;
            state_q    <= IDLE;
          end else if (redirect_valid_i) begin
            fetch_pc_q <= redirect_pc_al;
            state_q    <= DROP;
          end
        end
        DROP: begin
          // The in-flight access cannot be withdrawn; wait it out and discard it.
          if (redirect_valid_i) fetch_pc_q <= redirect_pc_al;
          if (imem_ack_i)       state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req_o     = (state_q == REQ) || (state_q == DROP);
  assign imem_addr_o    = req_addr_q;
  assign out_valid_o    = !fifo_empty;
  assign out_instr_o    = head_entry.instr;
  assign out_pc_o       = head_entry.pc;
  assign out_pc_plus8_o = head_entry.pc + PC_AHEAD;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus hand sequences
// for mid-request reset and PC wrap-around.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic        imem_req, imem_ack, redirect_valid, out_valid, out_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc, out_pc_plus8;
  logic        imem_req2, imem_ack2, out_valid2;
  logic [31:0] imem_addr2, imem_rdata2, out_instr2, out_pc2, out_pc_plus8_2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_instr_o(out_instr), .out_pc_o(out_pc), .out_pc_plus8_o(out_pc_plus8)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut_wrap (
    .clk(clk), .reset(reset2),
    .imem_req_o(imem_req2), .imem_addr_o(imem_addr2),
    .imem_ack_i(imem_ack2), .imem_rdata_i(imem_rdata2),
    .redirect_valid_i(1'b0), .redirect_pc_i(32'h0),
    .out_valid_o(out_valid2), .out_ready_i(1'b1),
    .out_instr_o(out_instr2), .out_pc_o(out_pc2), .out_pc_plus8_o(out_pc_plus8_2)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs for one cycle and the outputs expected during that same cycle.
  typedef struct {
    logic        ack;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ack, input logic redir, input logic [31:0] rpc,
                     input logic ready, input logic exp_req, input logic [31:0] exp_addr,
                     input logic exp_valid, input logic [31:0] exp_pc);
    vec_t v;
    v.ack = ack; v.redir = redir; v.rpc = rpc; v.ready = ready;
    v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_valid = exp_valid; v.exp_pc = exp_pc;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " imem_req"}, 32'(imem_req), 32'(v.exp_req));
    if (v.exp_req) check({tag, " imem_addr"}, imem_addr, v.exp_addr);
    check({tag, " out_valid"}, 32'(out_valid), 32'(v.exp_valid));
    if (v.exp_valid) begin
      check({tag, " out_pc"}, out_pc, v.exp_pc);
      check({tag, " out_instr"}, out_instr, instr_of(v.exp_pc));
      check({tag, " out_pc_plus8"}, out_pc_plus8, v.exp_pc + 32'd8);
    end
  endtask

  logic [31:0] wrap_addr [4];
  vec_t        vr;

  initial begin
    //   ack redir rpc           rdy req addr          val pc
    add(1, 0, 32'h0,        1, 1, 32'h0000_0000, 0, 32'h0);          // first req at RESET_PC
    add(1, 0, 32'h0,        1, 1, 32'h0000_0004, 1, 32'h0000_0000);  // back-to-back
    add(1, 0, 32'h0,        1, 1, 32'h0000_0008, 1, 32'h0000_0004);
    add(1, 0, 32'h0,        0, 1, 32'h0000_000C, 1, 32'h0000_0008);  // stall: fills FIFO
    add(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0000_0008);  // req dropped, ack ignored
    add(1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0000_0008);
    add(0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h0000_0008);  // drain
    add(0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h0000_000C);
    add(0, 0, 32'h0,        1, 1, 32'h0000_0010, 0, 32'h0);          // resumes at 0x10
    add(1, 0, 32'h0,        1, 1, 32'h0000_0010, 0, 32'h0);
    add(0, 0, 32'h0,        1, 1, 32'h0000_0014, 1, 32'h0000_0010);
    add(0, 1, 32'h0000_0100, 1, 1, 32'h0000_0014, 0, 32'h0);         // redirect, no ack -> DROP
    add(0, 0, 32'h0,        1, 1, 32'h0000_0014, 0, 32'h0);
    add(1, 0, 32'h0,        1, 1, 32'h0000_0014, 0, 32'h0);          // stale ack discarded
    add(0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0);
    add(1, 0, 32'h0,        1, 1, 32'h0000_0100, 0, 32'h0);
    add(1, 1, 32'h0000_0203, 1, 1, 32'h0000_0104, 1, 32'h0000_0100); // redirect with ack
    add(0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0);
    add(1, 0, 32'h0,        1, 1, 32'h0000_0200, 0, 32'h0);          // low bits forced to 0
    add(1, 0, 32'h0,        0, 1, 32'h0000_0204, 1, 32'h0000_0200);
    add(0, 1, 32'h0000_0300, 0, 0, 32'h0,        1, 32'h0000_0200);  // redirect in IDLE, full
    add(0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0);
    add(0, 1, 32'h0000_0400, 1, 1, 32'h0000_0300, 0, 32'h0);
    add(0, 1, 32'h0000_0500, 1, 1, 32'h0000_0300, 0, 32'h0);         // redirect in DROP
    add(1, 1, 32'h0000_0600, 1, 1, 32'h0000_0300, 0, 32'h0);         // DROP ack + redirect
    add(0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0);
    add(1, 0, 32'h0,        1, 1, 32'h0000_0600, 0, 32'h0);
    add(0, 0, 32'h0,        1, 1, 32'h0000_0604, 1, 32'h0000_0600);
    add(1, 0, 32'h0,        0, 1, 32'h0000_0604, 0, 32'h0);
    add(0, 0, 32'h0,        0, 1, 32'h0000_0608, 1, 32'h0000_0604);  // one entry, REQ pending

    reset = 1'b1; reset2 = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    imem_ack2 = 1'b0; imem_rdata2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset imem_req", 32'(imem_req), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      imem_ack       = vecs[i].ack;
      imem_rdata     = instr_of(vecs[i].exp_addr);
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].ready;
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset mid-request with an entry buffered drops everything at once.
    @(negedge clk);
    imem_ack = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midreset imem_req", 32'(imem_req), 32'd0);
    check("midreset out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("postreset idle req", 32'(imem_req), 32'd0);
    @(negedge clk);
    out_ready = 1'b1; imem_ack = 1'b1; imem_rdata = instr_of(32'h0);
    #1;
    vr = '{ack: 1'b1, redir: 1'b0, rpc: 32'h0, ready: 1'b1,
           exp_req: 1'b1, exp_addr: 32'h0, exp_valid: 1'b0, exp_pc: 32'h0};
    check_outputs("restart", vr);
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    vr = '{ack: 1'b0, redir: 1'b0, rpc: 32'h0, ready: 1'b1,
           exp_req: 1'b1, exp_addr: 32'h4, exp_valid: 1'b1, exp_pc: 32'h0};
    check_outputs("restart2", vr);

    // PC wrap from RESET_PC = 0xFFFF_FFF8 with zero-wait memory.
    wrap_addr[0] = 32'hFFFF_FFF8; wrap_addr[1] = 32'hFFFF_FFFC;
    wrap_addr[2] = 32'h0000_0000; wrap_addr[3] = 32'h0000_0004;
    @(negedge clk);
    reset2 = 1'b0;
    #1;
    check("wrap reset req", 32'(imem_req2), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      imem_ack2   = 1'b1;
      imem_rdata2 = instr_of(wrap_addr[k]);
      #1;
      check($sformatf("wrap%0d req", k), 32'(imem_req2), 32'd1);
      check($sformatf("wrap%0d addr", k), imem_addr2, wrap_addr[k]);
      check($sformatf("wrap%0d valid", k), 32'(out_valid2), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) begin
        check($sformatf("wrap%0d pc", k), out_pc2, wrap_addr[k-1]);
        check($sformatf("wrap%0d instr", k), out_instr2, instr_of(wrap_addr[k-1]));
      end
      if (k == 2) check("wrap plus8 of FFFFFFFC", out_pc_plus8_2, 32'h0000_0004);
      if (k == 1) check("wrap plus8 of FFFFFFF8", out_pc_plus8_2, 32'h0000_0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
